// File: rtl/mesh_terminal_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mesh_pkg                                                   |
// | Brief   : Packet field constants and destination screen for the     |
// |           mesh terminal transmitter.                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mesh_pkg;

    localparam int          DEST_W       = 4;
    localparam int          HDR_W        = 17;
    localparam logic [7:0]  BCST_ID      = 8'hFF;
    localparam logic [7:0]  NXT_JMP_INIT = 8'h00;

    // Edge terminals sit on row 0/ROWS+1 or column 0/COLUMNS+1, never on a corner.
    function automatic logic dest_is_legal(
        input logic [DEST_W-1:0] row,
        input logic [DEST_W-1:0] col,
        input int                rows,
        input int                cols
    );
        int r;
        int c;
        r = int'(row);
        c = int'(col);
        return ((r == 0 || r == rows + 1) && (c >= 1 && c <= cols)) ||
               ((c == 0 || c == cols + 1) && (r >= 1 && r <= rows));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_terminal_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : mesh_terminal_tx_if                                      |
// | Brief     : Local write port plus router pndng/data/popin handshake. |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface mesh_terminal_tx_if #(
    parameter int PAKG_SIZE = 32
);
    import mesh_pkg::*;

    logic                   wr_i;
    logic [DEST_W-1:0]      wr_row_i;
    logic [DEST_W-1:0]      wr_col_i;
    logic                   wr_mode_i;
    logic                   wr_bcst_i;
    logic [PAKG_SIZE-18:0]  wr_payload_i;
    logic                   full_o;
    logic                   pndng_o;
    logic [PAKG_SIZE-1:0]   data_o;
    logic                   popin_i;

    modport slave (
        input  wr_i, wr_row_i, wr_col_i, wr_mode_i, wr_bcst_i, wr_payload_i, popin_i,
        output full_o, pndng_o, data_o
    );

    modport master (
        output wr_i, wr_row_i, wr_col_i, wr_mode_i, wr_bcst_i, wr_payload_i, popin_i,
        input  full_o, pndng_o, data_o
    );

endinterface
`default_nettype wire

// File: rtl/mesh_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mesh_tx_fifo                                                |
// | Brief  : Synchronous FIFO; head is shown on o_data, zero when empty. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mesh_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk_i,
    input  wire logic                       rst_i,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [WIDTH-1:0]           i_data,
    output logic      [WIDTH-1:0]           o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mesh_terminal_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mesh_terminal_tx                                            |
// | Brief  : Edge-terminal packet source: format, screen, queue, count.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mesh_terminal_tx
    import mesh_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 4,
    parameter int PAKG_SIZE  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    mesh_terminal_tx_if.slave           bus,
    output logic      [CNT_W-1:0]       sent_cnt_o,
    output logic      [CNT_W-1:0]       drop_cnt_o,
    output logic      [CNT_W-1:0]       ovf_cnt_o,
    output logic                        err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PAKG_SIZE-1:0]  w_pkt;
    logic [7:0]            w_dest;
    logic                  w_legal;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [AW:0]           w_count;
    logic [PAKG_SIZE-1:0]  w_head;

    logic [CNT_W-1:0]      r_sent_cnt;
    logic [CNT_W-1:0]      r_drop_cnt;
    logic [CNT_W-1:0]      r_ovf_cnt;
    logic                  r_err;

    assign w_dest  = bus.wr_bcst_i ? BCST_ID : {bus.wr_row_i, bus.wr_col_i};
    assign w_pkt   = {NXT_JMP_INIT, w_dest, bus.wr_mode_i, bus.wr_payload_i};
    assign w_legal = bus.wr_bcst_i ||
                     dest_is_legal(bus.wr_row_i, bus.wr_col_i, ROWS, COLUMNS);

    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign w_pop  = bus.popin_i && !w_empty;
    assign w_push = bus.wr_i && w_legal && (!w_full || bus.popin_i);

    mesh_tx_fifo #(
        .WIDTH (PAKG_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pkt),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sent_cnt <= '0;
            r_drop_cnt <= '0;
            r_ovf_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop && r_sent_cnt != '1) begin
                r_sent_cnt <= r_sent_cnt + CNT_W'(1);
            end
            if (bus.wr_i && !w_legal && r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (bus.wr_i && w_legal && w_full && !bus.popin_i && r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
            if (bus.popin_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.full_o  = w_full;
    assign bus.pndng_o = (w_count != '0);
    assign bus.data_o  = w_head;
    assign sent_cnt_o  = r_sent_cnt;
    assign drop_cnt_o  = r_drop_cnt;
    assign ovf_cnt_o   = r_ovf_cnt;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mesh_terminal_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mesh_terminal_tx                                         |
// | Brief  : Scoreboard bench for mesh_terminal_tx (4x4 mesh, 32b, 16).  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mesh_terminal_tx;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] sent_cnt_o;
    logic [15:0] drop_cnt_o;
    logic [15:0] ovf_cnt_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    int          m_sent, m_drop, m_ovf;
    logic        m_err;

    mesh_terminal_tx_if #(.PAKG_SIZE(32)) bus ();

    mesh_terminal_tx #(
        .ROWS       (4),
        .COLUMNS    (4),
        .PAKG_SIZE  (32),
        .FIFO_DEPTH (16),
        .CNT_W      (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .sent_cnt_o (sent_cnt_o),
        .drop_cnt_o (drop_cnt_o),
        .ovf_cnt_o  (ovf_cnt_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic legal_dest(input int r, input int c);
        return ((r == 0 || r == 5) && c >= 1 && c <= 4) ||
               ((c == 0 || c == 5) && r >= 1 && r <= 4);
    endfunction

    function automatic logic [31:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                           input logic m, input logic b, input logic [14:0] p);
        logic [31:0] v;
        v = 32'h0;
        if (b) v = v | (32'hFF << 16);
        else   v = v | ({28'h0, r} << 20) | ({28'h0, c} << 16);
        v = v | ({31'h0, m} << 15) | {17'h0, p};
        return v;
    endfunction

    // One clock of stimulus; the model is updated and the head checked before the edge.
    task automatic cycle(input logic wr, input logic [3:0] row, input logic [3:0] col,
                         input logic mode, input logic bcst, input logic [14:0] pl,
                         input logic pop);
        int   sz;
        logic lg;
        bus.wr_i         = wr;
        bus.wr_row_i     = row;
        bus.wr_col_i     = col;
        bus.wr_mode_i    = mode;
        bus.wr_bcst_i    = bcst;
        bus.wr_payload_i = pl;
        bus.popin_i      = pop;
        sz = exp_q.size();
        lg = bcst || legal_dest(int'(row), int'(col));
        if (pop && sz > 0) begin
            n_checks++;
            if (bus.data_o !== exp_q[0])
                $display("FAIL sb_head: data_o=%h expected=%h", bus.data_o, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            m_sent++;
        end else if (pop) begin
            m_err = 1'b1;
        end
        if (wr) begin
            if (!lg)                  m_drop++;
            else if (sz == 16 && !pop) m_ovf++;
            else                      exp_q.push_back(mk_pkt(row, col, mode, bcst, pl));
        end
        @(posedge clk_i);
        #1;
        bus.wr_i    = 1'b0;
        bus.popin_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        m_sent = 0; m_drop = 0; m_ovf = 0; m_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.pndng_o !== 1'b0) $display("FAIL rst_pndng: got %b want 0", bus.pndng_o); else n_pass++;
        n_checks++; if (bus.data_o !== 32'h0) $display("FAIL rst_data: got %h want 0", bus.data_o); else n_pass++;
        n_checks++; if (bus.full_o !== 1'b0) $display("FAIL rst_full: got %b want 0", bus.full_o); else n_pass++;
        n_checks++; if (sent_cnt_o !== 16'h0 || drop_cnt_o !== 16'h0 || ovf_cnt_o !== 16'h0)
            $display("FAIL rst_cnt: got %h/%h/%h want 0/0/0", sent_cnt_o, drop_cnt_o, ovf_cnt_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
    endtask

    task automatic test_single();
        cycle(1'b1, 4'd5, 4'd2, 1'b1, 1'b0, 15'h1234, 1'b0);
        n_checks++; if (bus.pndng_o !== 1'b1) $display("FAIL single_pndng: got %b want 1", bus.pndng_o); else n_pass++;
        n_checks++; if (bus.data_o !== 32'h0052_9234) $display("FAIL single_data: got %h want 00529234", bus.data_o); else n_pass++;
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 15'h0, 1'b1);
        n_checks++; if (bus.pndng_o !== 1'b0) $display("FAIL single_pop_pndng: got %b want 0", bus.pndng_o); else n_pass++;
        n_checks++; if (sent_cnt_o !== 16'd1) $display("FAIL single_sent: got %0d want 1", sent_cnt_o); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 4'd0, 4'((i % 4) + 1), i[0], 1'b0, 15'(i * 3 + 7), 1'b0);
        n_checks++; if (bus.full_o !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.full_o); else n_pass++;
        cycle(1'b1, 4'd5, 4'd4, 1'b0, 1'b0, 15'h7EEE, 1'b0);
        n_checks++; if (ovf_cnt_o !== 16'(m_ovf) || m_ovf != 1)
            $display("FAIL fill_ovf: got %0d want 1", ovf_cnt_o); else n_pass++;
        n_checks++; if (bus.data_o !== exp_q[0]) $display("FAIL fill_hold: got %h want %h", bus.data_o, exp_q[0]); else n_pass++;
        cycle(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 15'h5A5A, 1'b1);
        n_checks++; if (bus.full_o !== 1'b1) $display("FAIL fill_wrpop_full: got %b want 1", bus.full_o); else n_pass++;
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 15'h0, 1'b1);
        n_checks++; if (bus.pndng_o !== 1'b0 || exp_q.size() != 0)
            $display("FAIL fill_drain_pndng: got %b want 0", bus.pndng_o); else n_pass++;
        n_checks++; if (sent_cnt_o !== 16'(m_sent)) $display("FAIL fill_sent: got %0d want %0d", sent_cnt_o, m_sent); else n_pass++;
    endtask

    task automatic test_illegal();
        cycle(1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 15'h1111, 1'b0);
        cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 15'h2222, 1'b0);
        n_checks++; if (drop_cnt_o !== 16'd2) $display("FAIL illegal_drop: got %0d want 2", drop_cnt_o); else n_pass++;
        n_checks++; if (bus.pndng_o !== 1'b0) $display("FAIL illegal_pndng: got %b want 0", bus.pndng_o); else n_pass++;
        cycle(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 15'h0ABC, 1'b0);
        n_checks++; if (bus.pndng_o !== 1'b1 || bus.data_o[23:16] !== 8'hFF)
            $display("FAIL bcst_dest: pndng=%b dest=%h want 1/ff", bus.pndng_o, bus.data_o[23:16]); else n_pass++;
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 15'h0, 1'b1);
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 4'd1, 4'd5, 1'b0, 1'b0, 15'h3333, 1'b0);
        cycle(1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 15'h4444, 1'b1);
        n_checks++; if (bus.pndng_o !== 1'b1 || exp_q.size() != 1)
            $display("FAIL simul_pndng: got %b want 1", bus.pndng_o); else n_pass++;
        n_checks++; if (bus.data_o !== 32'h0040_C444) $display("FAIL simul_data: got %h want 0040c444", bus.data_o); else n_pass++;
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 15'h0, 1'b1);
        n_checks++; if (bus.pndng_o !== 1'b0) $display("FAIL simul_empty: got %b want 0", bus.pndng_o); else n_pass++;
    endtask

    task automatic test_empty_pop();
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 15'h0, 1'b1);
        n_checks++; if (err_o !== 1'b1) $display("FAIL emptypop_err: got %b want 1", err_o); else n_pass++;
        n_checks++; if (sent_cnt_o !== 16'(m_sent)) $display("FAIL emptypop_sent: got %0d want %0d", sent_cnt_o, m_sent); else n_pass++;
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 15'h0, 1'b0);
        n_checks++; if (err_o !== 1'b1) $display("FAIL emptypop_sticky: got %b want 1", err_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 4'(i % 4 + 1), 4'd5, 1'b0, 1'b0, 15'(i + 100), 1'b0);
        do_reset();
        n_checks++; if (bus.pndng_o !== 1'b0 || bus.data_o !== 32'h0)
            $display("FAIL rstmid_head: pndng=%b data=%h want 0/0", bus.pndng_o, bus.data_o); else n_pass++;
        n_checks++; if (sent_cnt_o !== 16'h0 || drop_cnt_o !== 16'h0 || ovf_cnt_o !== 16'h0 || err_o !== 1'b0)
            $display("FAIL rstmid_cnt: got %h/%h/%h/%b want 0", sent_cnt_o, drop_cnt_o, ovf_cnt_o, err_o); else n_pass++;
        cycle(1'b1, 4'd0, 4'd3, 1'b1, 1'b0, 15'h0777, 1'b0);
        n_checks++; if (bus.pndng_o !== 1'b1 || bus.data_o !== 32'h0003_8777)
            $display("FAIL rstmid_write: pndng=%b data=%h want 1/00038777", bus.pndng_o, bus.data_o); else n_pass++;
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 15'h0, 1'b1);
        n_checks++; if (sent_cnt_o !== 16'd1) $display("FAIL rstmid_sent: got %0d want 1", sent_cnt_o); else n_pass++;
    endtask

    initial begin
        bus.wr_i = 1'b0; bus.wr_row_i = '0; bus.wr_col_i = '0; bus.wr_mode_i = 1'b0;
        bus.wr_bcst_i = 1'b0; bus.wr_payload_i = '0; bus.popin_i = 1'b0;
        m_sent = 0; m_drop = 0; m_ovf = 0; m_err = 1'b0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_illegal();
        test_simultaneous();
        test_empty_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
